brew_counter: RTL and testbench
===============================

BREW_COUNTER -- requirements
Module: brew_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (minimum 2).
REQ-002 The block SHALL have parameter PRESCALE, default 50000000, giving clock cycles per count tick (minimum 1; 1 = tick every clock).
REQ-003 The block SHALL have port brew_counter_clock  input  1  single clock; all logic on the rising edge.
REQ-004 The block SHALL have port brew_counter_rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port brew_counter_ld  input  1  load preset; highest priority after reset.
REQ-006 The block SHALL have port brew_counter_en  input  1  run request: 1 = run, 0 = hold.
REQ-007 The block SHALL have port brew_counter_ud  input  1  direction: 1 = down, 0 = up.
REQ-008 The block SHALL have port brew_counter_mode  input  2  terminal mode: 00 saturate, 01 wrap, 10 auto-reload, 11 reserved (treated as 00).
REQ-009 The block SHALL have port brew_counter_pre_value  input  WIDTH  preset and reload value.
REQ-010 The block SHALL have port brew_counter_limit  input  WIDTH  up-count terminal value and down-wrap target.
REQ-011 The block SHALL have port brew_counter_cnt_value  output  WIDTH  registered count.
REQ-012 The block SHALL have port brew_counter_tc  output  1  registered terminal-count pulse, one clock wide.
REQ-013 The block SHALL have port brew_counter_busy  output  1  high while state is RUN or HOLD.

Function
REQ-014 The state machine SHALL have states IDLE, RUN, HOLD and DONE.
- IDLE -> RUN on en=1.
- RUN -> HOLD on en=0.
- HOLD -> RUN on en=1.
- DONE is left only by ld or reset; en is ignored in DONE.
REQ-015 ld=1 SHALL, at the clock edge:
- set cnt_value to pre_value and clear the prescaler;
- force state IDLE and tc 0;
- override en, ud and any pending tick.
REQ-016 The prescaler SHALL advance only in RUN, hold its value in HOLD, and clear in IDLE and DONE.
REQ-017 A tick SHALL occur in a RUN cycle whose prescaler value equals PRESCALE-1; the prescaler then returns to 0.
REQ-018 At a tick, terminal SHALL be defined as:
- ud=1: cnt_value == 0;
- ud=0: cnt_value == limit.
ud is sampled at each tick.
REQ-019 At a non-terminal tick, cnt_value SHALL step by one: minus 1 when ud=1, plus 1 when ud=0, modulo 2^WIDTH.
REQ-020 At a terminal tick, the block SHALL act per mode and pulse tc for exactly the one cycle after that edge.
- Saturate: hold cnt_value, go to DONE.
- Wrap: down loads limit, up loads 0; stay in RUN.
- Auto-reload: load pre_value; stay in RUN.
REQ-021 A loaded pre_value above limit in up mode SHALL count through the 2^WIDTH rollover until it equals limit; no clamping.
REQ-022 In IDLE, HOLD and DONE, cnt_value SHALL be held, except when ld=1.
REQ-023 The first tick after IDLE -> RUN SHALL occur PRESCALE cycles after entering RUN.
REQ-024 Tick counting SHALL resume after HOLD -> RUN from the retained prescaler value.
REQ-025 busy SHALL be registered and change in the same cycle as the state register.

Reset
REQ-026 While reset is high, outputs SHALL be: cnt_value 0, tc 0, busy 0; state SHALL be IDLE and the prescaler 0.
REQ-027 Reset assertion SHALL act immediately without a clock and SHALL abort any RUN, HOLD or DONE state.
REQ-028 After reset deasserts, the first state change SHALL occur at the first clock edge with en=1 or ld=1.

Structure
REQ-029 A shared package brew_counter_pkg SHALL hold:
- the state encodings (IDLE, RUN, HOLD, DONE);
- the mode encodings MODE_SAT, MODE_WRAP, MODE_RELOAD.
REQ-030 The prescaler SHALL be a separate sub-module brew_tick_gen with:
- parameter PRESCALE;
- inputs run and clear;
- output tick.
REQ-031 The implementation SHALL contain no latches and no gated or derived clocks.

Verification (WIDTH=3, PRESCALE=1 unless stated)
REQ-032 Saturate down: ld with pre_value=3, mode=00, ud=1, en=1 -> cnt 3,2,1,0; tc pulses once; busy drops; state DONE; further en has no effect.
REQ-033 Wrap up: pre_value=5, limit=6, mode=01, ud=0 -> cnt 5,6,0,1; tc is high exactly one cycle after 6->0; busy stays 1.
REQ-034 Auto-reload down: pre_value=2, mode=10, ud=1 -> cnt 2,1,0,2,1,0,2; tc pulses after each 0->2 edge.
REQ-035 PRESCALE=4 hold/resume: en high 6 cycles, low 3 cycles, then high -> first decrement after 4 cycles; next after 4 more RUN cycles excluding HOLD; cnt frozen while en=0.
REQ-036 ld priority: ld=1 and tick in the same cycle with pre_value=7 -> cnt=7, state IDLE, no tc.
REQ-037 Async reset: assert rst mid-RUN between clock edges -> cnt 0, tc 0, busy 0 immediately; IDLE after release.

Source files
------------

// File: rtl/brew_counter_pkg.sv
// Shared types for the brew counter: controller states and terminal-mode codes.
package brew_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] MODE_SAT    = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b01;
    localparam logic [1:0] MODE_RELOAD = 2'b10;

endpackage

// File: rtl/brew_tick_gen.sv
// Prescaler: raises tick on the run cycle whose count is PRESCALE-1, then restarts at 0.
module brew_tick_gen
    import brew_counter_pkg::*;
#(
    parameter int PRESCALE = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick    = run && !clear && (count_q == LAST);
        count_d = count_q;
        if (clear || tick) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/brew_counter.sv
// Prescaled up/down counter with saturate, wrap and auto-reload terminal modes.
module brew_counter
    import brew_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000000
) (
    input  logic             brew_counter_clock,
    input  logic             brew_counter_rst,
    input  logic             brew_counter_ld,
    input  logic             brew_counter_en,
    input  logic             brew_counter_ud,
    input  logic [1:0]       brew_counter_mode,
    input  logic [WIDTH-1:0] brew_counter_pre_value,
    input  logic [WIDTH-1:0] brew_counter_limit,
    output logic [WIDTH-1:0] brew_counter_cnt_value,
    output logic             brew_counter_tc,
    output logic             brew_counter_busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             terminal;

    // Load restarts the prescaler as well, so a pending tick is discarded.
    brew_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk   (brew_counter_clock),
        .rst   (brew_counter_rst),
        .run   (state_q == RUN),
        .clear (brew_counter_ld || state_q == IDLE || state_q == DONE),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        terminal = brew_counter_ud ? (cnt_q == '0) : (cnt_q == brew_counter_limit);

        if (brew_counter_ld) begin
            cnt_d   = brew_counter_pre_value;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (brew_counter_en) state_d = RUN;
                RUN: begin
                    if (tick && !terminal) begin
                        cnt_d = brew_counter_ud ? cnt_q - ONE : cnt_q + ONE;
                    end else if (tick) begin
                        tc_d = 1'b1;
                        case (brew_counter_mode)
                            MODE_WRAP:   cnt_d = brew_counter_ud ? brew_counter_limit : '0;
                            MODE_RELOAD: cnt_d = brew_counter_pre_value;
                            default:     state_d = DONE;
                        endcase
                    end
                    // The tick of this cycle still counts even when en drops with it.
                    if (state_d == RUN && !brew_counter_en) state_d = HOLD;
                end
                HOLD: if (brew_counter_en) state_d = RUN;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    always_ff @(posedge brew_counter_clock or posedge brew_counter_rst) begin
        if (brew_counter_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign brew_counter_cnt_value = cnt_q;
    assign brew_counter_tc        = tc_q;
    assign brew_counter_busy      = busy_q;

endmodule

// File: tb/tb_brew_counter.sv
// Bench for brew_counter: two instances (PRESCALE 1 and 4) against a cycle-level behavioural model.
module tb_brew_counter;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld;
    logic         en;
    logic         ud;
    logic [1:0]   mode;
    logic [W-1:0] pre;
    logic [W-1:0] lim;

    logic [W-1:0] cnt  [2];
    logic         tc   [2];
    logic         busy [2];

    int errors = 0;
    int checks = 0;

    int m_st  [2];
    int m_cnt [2];
    int m_ps  [2];
    int m_tc  [2];

    brew_counter #(.WIDTH(W), .PRESCALE(1)) dut_p1 (
        .brew_counter_clock     (clk),
        .brew_counter_rst       (rst),
        .brew_counter_ld        (ld),
        .brew_counter_en        (en),
        .brew_counter_ud        (ud),
        .brew_counter_mode      (mode),
        .brew_counter_pre_value (pre),
        .brew_counter_limit     (lim),
        .brew_counter_cnt_value (cnt[0]),
        .brew_counter_tc        (tc[0]),
        .brew_counter_busy      (busy[0])
    );

    brew_counter #(.WIDTH(W), .PRESCALE(4)) dut_p4 (
        .brew_counter_clock     (clk),
        .brew_counter_rst       (rst),
        .brew_counter_ld        (ld),
        .brew_counter_en        (en),
        .brew_counter_ud        (ud),
        .brew_counter_mode      (mode),
        .brew_counter_pre_value (pre),
        .brew_counter_limit     (lim),
        .brew_counter_cnt_value (cnt[1]),
        .brew_counter_tc        (tc[1]),
        .brew_counter_busy      (busy[1])
    );

    always #5 clk = ~clk;

    // Reference model: prescaler is "RUN cycles since last tick", count is plain modular arithmetic.
    task automatic model_step(input int k);
        int  p;
        bit  tick;
        bit  term;
        p    = (k == 0) ? 1 : 4;
        tick = (m_st[k] == M_RUN) && (m_ps[k] == p - 1);
        m_tc[k] = 0;
        if (ld) begin
            m_cnt[k] = int'(pre);
            m_st[k]  = M_IDLE;
            m_ps[k]  = 0;
        end else if (m_st[k] == M_IDLE) begin
            m_ps[k] = 0;
            if (en) m_st[k] = M_RUN;
        end else if (m_st[k] == M_HOLD) begin
            if (en) m_st[k] = M_RUN;
        end else if (m_st[k] == M_DONE) begin
            m_ps[k] = 0;
        end else begin
            m_ps[k] = tick ? 0 : m_ps[k] + 1;
            if (tick) begin
                term = ud ? (m_cnt[k] == 0) : (m_cnt[k] == int'(lim));
                if (!term) begin
                    m_cnt[k] = ud ? (m_cnt[k] + MOD - 1) % MOD : (m_cnt[k] + 1) % MOD;
                end else begin
                    m_tc[k] = 1;
                    if (mode == 2'd1)      m_cnt[k] = ud ? int'(lim) : 0;
                    else if (mode == 2'd2) m_cnt[k] = int'(pre);
                    else                   m_st[k]  = M_DONE;
                end
            end
            if (m_st[k] == M_RUN && !en) m_st[k] = M_HOLD;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k]  = M_IDLE;
                m_cnt[k] = 0;
                m_ps[k]  = 0;
                m_tc[k]  = 0;
            end else begin
                model_step(k);
            end
        end
    end

    // Continuous scoreboard, sampled on the inactive edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (int'(cnt[k]) !== m_cnt[k]) begin
                errors++;
                $display("FAIL sb_cnt[%0d] t=%0t got=%0d exp=%0d", k, $time, cnt[k], m_cnt[k]);
            end
            checks++;
            if (int'(tc[k]) !== m_tc[k]) begin
                errors++;
                $display("FAIL sb_tc[%0d] t=%0t got=%0b exp=%0d", k, $time, tc[k], m_tc[k]);
            end
            checks++;
            if (busy[k] !== (m_st[k] == M_RUN || m_st[k] == M_HOLD)) begin
                errors++;
                $display("FAIL sb_busy[%0d] t=%0t got=%0b exp_state=%0d", k, $time, busy[k], m_st[k]);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic l, input logic e, input logic u, input logic [1:0] m,
                          input logic [W-1:0] p, input logic [W-1:0] li);
        ld = l; en = e; ud = u; mode = m; pre = p; lim = li;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 2'd0, 3'd0, 3'd0);
        #3;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] !== 3'd0 || tc[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] got cnt=%0d tc=%0b busy=%0b exp 0/0/0", k, cnt[k], tc[k], busy[k]);
            end
        end
        next();
        rst = 1'b0;
        next();
        next();
        checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b/%0b exp 0/0", busy[0], busy[1]);
        end
    endtask

    task automatic test_saturate_down();
        int exp_cnt [5] = '{3, 2, 1, 0, 0};
        int exp_bsy [5] = '{1, 1, 1, 1, 0};
        int pulses = 0;
        set_in(1, 1, 1, 2'd0, 3'd3, 3'd5);
        next();
        checks++;
        if (cnt[0] !== 3'd3 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_load got cnt=%0d busy=%0b exp 3/0", cnt[0], busy[0]);
        end
        ld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next();
            if (tc[0] === 1'b1) pulses++;
            checks++;
            if (int'(cnt[0]) !== exp_cnt[i] || int'(busy[0]) !== exp_bsy[i]) begin
                errors++;
                $display("FAIL sat_seq[%0d] got cnt=%0d busy=%0b exp %0d/%0d", i, cnt[0], busy[0], exp_cnt[i], exp_bsy[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            en = i[0];
            next();
            if (tc[0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || cnt[0] !== 3'd0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_done got pulses=%0d cnt=%0d busy=%0b exp 1/0/0", pulses, cnt[0], busy[0]);
        end
    endtask

    task automatic test_wrap_up();
        int exp_cnt [4] = '{5, 6, 0, 1};
        int exp_tc  [4] = '{0, 0, 1, 0};
        set_in(1, 0, 0, 2'd1, 3'd5, 3'd6);
        next();
        ld = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            checks++;
            if (int'(cnt[0]) !== exp_cnt[i] || int'(tc[0]) !== exp_tc[i] || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_seq[%0d] got cnt=%0d tc=%0b busy=%0b exp %0d/%0d/1",
                         i, cnt[0], tc[0], busy[0], exp_cnt[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_reload_down();
        int exp_cnt [7] = '{2, 1, 0, 2, 1, 0, 2};
        int exp_tc  [7] = '{0, 0, 0, 1, 0, 0, 1};
        set_in(1, 0, 1, 2'd2, 3'd2, 3'd6);
        next();
        ld = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            next();
            checks++;
            if (int'(cnt[0]) !== exp_cnt[i] || int'(tc[0]) !== exp_tc[i]) begin
                errors++;
                $display("FAIL reload_seq[%0d] got cnt=%0d tc=%0b exp %0d/%0d",
                         i, cnt[0], tc[0], exp_cnt[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_hold_resume();
        int exp_cnt [13] = '{5, 5, 5, 5, 4, 4, 4, 4, 4, 4, 4, 3, 3};
        set_in(1, 0, 1, 2'd0, 3'd5, 3'd7);
        next();
        ld = 1'b0;
        for (int i = 0; i < 13; i++) begin
            en = (i < 6 || i >= 9);
            next();
            checks++;
            if (int'(cnt[1]) !== exp_cnt[i] || busy[1] !== 1'b1) begin
                errors++;
                $display("FAIL hold_seq[%0d] got cnt=%0d busy=%0b exp %0d/1", i, cnt[1], busy[1], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_ld_priority();
        set_in(1, 0, 0, 2'd1, 3'd1, 3'd6);
        next();
        ld = 1'b0;
        en = 1'b1;
        next();
        next();
        checks++;
        if (cnt[0] !== 3'd2) begin
            errors++;
            $display("FAIL ldp_pre got cnt=%0d exp 2", cnt[0]);
        end
        ld  = 1'b1;
        pre = 3'd7;
        next();
        checks++;
        if (cnt[0] !== 3'd7 || busy[0] !== 1'b0 || tc[0] !== 1'b0) begin
            errors++;
            $display("FAIL ldp got cnt=%0d busy=%0b tc=%0b exp 7/0/0", cnt[0], busy[0], tc[0]);
        end
        ld = 1'b0;
        en = 1'b0;
        next();
        checks++;
        if (cnt[0] !== 3'd7 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ldp_idle got cnt=%0d busy=%0b exp 7/0", cnt[0], busy[0]);
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 2'd1, 3'd4, 3'd7);
        next();
        ld = 1'b0;
        en = 1'b1;
        next();
        next();
        checks++;
        if (busy[0] !== 1'b1 || cnt[0] !== 3'd5) begin
            errors++;
            $display("FAIL arst_pre got busy=%0b cnt=%0d exp 1/5", busy[0], cnt[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] !== 3'd0 || tc[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL arst[%0d] got cnt=%0d tc=%0b busy=%0b exp 0/0/0", k, cnt[k], tc[k], busy[k]);
            end
        end
        next();
        rst = 1'b0;
        en  = 1'b0;
        next();
        checks++;
        if (busy[0] !== 1'b0 || cnt[0] !== 3'd0) begin
            errors++;
            $display("FAIL arst_idle got busy=%0b cnt=%0d exp 0/0", busy[0], cnt[0]);
        end
        en = 1'b1;
        next();
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL arst_run got busy=%0b exp 1", busy[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ld   = ($urandom_range(0, 11) == 0);
            en   = ($urandom_range(0, 4) != 0);
            ud   = $urandom_range(0, 1);
            mode = 2'($urandom_range(0, 3));
            pre  = W'($urandom_range(0, MOD - 1));
            lim  = W'($urandom_range(0, MOD - 1));
            next();
        end
    endtask

    initial begin
        test_reset();
        test_saturate_down();
        test_wrap_up();
        test_reload_down();
        test_hold_resume();
        test_ld_priority();
        test_async_reset();
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
